// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: state encodings, command
// encodings and pin widths used by the arbiter and the command engines.
package sdram_pkg;

    localparam int CMD_W  = 4;
    localparam int ADDR_W = 12;
    localparam int BANK_W = 2;

    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_ARBIT = 5'b00010;
    localparam logic [4:0] ST_AREF  = 5'b00100;
    localparam logic [4:0] ST_WRITE = 5'b01000;
    localparam logic [4:0] ST_READ  = 5'b10000;

    typedef enum logic [4:0] {
        IDLE  = ST_IDLE,
        ARBIT = ST_ARBIT,
        AREF  = ST_AREF,
        WRITE = ST_WRITE,
        READ  = ST_READ
    } arb_state_t;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_WR   = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_RD   = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_MRS  = 4'b0000;

endpackage

// File: rtl/sdram_svc_timer.sv
// Service watchdog: counts cycles while enabled and flags the cycle in which
// the count reaches MAX_CYC-1, so the owner can abandon a stuck service.
module sdram_svc_timer #(
    parameter int MAX_CYC = 1024,
    parameter int CNT_W   = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = i_enable && (r_cnt == CNT_W'(MAX_CYC - 1));

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: after init hands over, grants refresh, write and
// read engines one at a time and drives the granted engine onto the pins.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int MAX_CYC = 1024,
    parameter int CNT_W   = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flag_init_end,
    input  logic [CMD_W-1:0]  i_init_cmd,
    input  logic [ADDR_W-1:0] i_init_addr,
    input  logic              i_ref_req,
    input  logic              i_flag_ref_end,
    input  logic [CMD_W-1:0]  i_aref_cmd,
    input  logic [ADDR_W-1:0] i_aref_addr,
    input  logic              i_wr_req,
    input  logic              i_flag_wr_end,
    input  logic [CMD_W-1:0]  i_wr_cmd,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [BANK_W-1:0] i_wr_bank,
    input  logic              i_rd_req,
    input  logic              i_flag_rd_end,
    input  logic [CMD_W-1:0]  i_rd_cmd,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [BANK_W-1:0] i_rd_bank,
    output logic              o_ref_en,
    output logic              o_wr_en,
    output logic              o_rd_en,
    output logic              o_ref_break,
    output logic [CMD_W-1:0]  o_sdram_cmd,
    output logic [ADDR_W-1:0] o_sdram_addr,
    output logic [BANK_W-1:0] o_sdram_bank,
    output logic [4:0]        o_arb_state,
    output logic              o_timeout_err
);

    arb_state_t r_state;
    logic       r_last_wr;
    logic       w_service;
    logic       w_end;
    logic       w_expired;

    assign w_service = (r_state == AREF) || (r_state == WRITE) || (r_state == READ);

    // Only the end flag of the engine currently holding the bus is honoured.
    always_comb begin
        w_end = 1'b0;
        case (r_state)
            AREF:    w_end = i_flag_ref_end;
            WRITE:   w_end = i_flag_wr_end;
            READ:    w_end = i_flag_rd_end;
            default: w_end = 1'b0;
        endcase
    end

    sdram_svc_timer #(
        .MAX_CYC (MAX_CYC),
        .CNT_W   (CNT_W)
    ) u_svc_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (!w_service),
        .i_enable  (w_service),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_last_wr     <= 1'b0;
            o_ref_en      <= 1'b0;
            o_wr_en       <= 1'b0;
            o_rd_en       <= 1'b0;
            o_ref_break   <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            o_ref_en    <= 1'b0;
            o_wr_en     <= 1'b0;
            o_rd_en     <= 1'b0;
            o_ref_break <= ((r_state == WRITE) || (r_state == READ)) && i_ref_req;
            case (r_state)
                IDLE: begin
                    if (i_flag_init_end) r_state <= ARBIT;
                end
                ARBIT: begin
                    // A simultaneous write/read pair alternates on the last burst type.
                    if (i_ref_req) begin
                        r_state  <= AREF;
                        o_ref_en <= 1'b1;
                    end else if (i_wr_req && !(i_rd_req && r_last_wr)) begin
                        r_state   <= WRITE;
                        o_wr_en   <= 1'b1;
                        r_last_wr <= 1'b1;
                    end else if (i_rd_req) begin
                        r_state   <= READ;
                        o_rd_en   <= 1'b1;
                        r_last_wr <= 1'b0;
                    end
                end
                AREF, WRITE, READ: begin
                    if (w_end) begin
                        r_state <= ARBIT;
                    end else if (w_expired) begin
                        r_state       <= ARBIT;
                        o_timeout_err <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_sdram_cmd  = CMD_NOP;
        o_sdram_addr = '0;
        o_sdram_bank = '0;
        case (r_state)
            IDLE: begin
                o_sdram_cmd  = i_init_cmd;
                o_sdram_addr = i_init_addr;
            end
            AREF: begin
                o_sdram_cmd  = i_aref_cmd;
                o_sdram_addr = i_aref_addr;
            end
            WRITE: begin
                o_sdram_cmd  = i_wr_cmd;
                o_sdram_addr = i_wr_addr;
                o_sdram_bank = i_wr_bank;
            end
            READ: begin
                o_sdram_cmd  = i_rd_cmd;
                o_sdram_addr = i_rd_addr;
                o_sdram_bank = i_rd_bank;
            end
            default: begin
                o_sdram_cmd  = CMD_NOP;
                o_sdram_addr = '0;
                o_sdram_bank = '0;
            end
        endcase
    end

    assign o_arb_state = r_state;

endmodule

// File: tb/tb_sdram_arbit.sv
// Testbench for sdram_arbit: directed scenarios plus a randomized phase, all
// compared cycle by cycle against a behavioural model of the arbitration rules.
module tb_sdram_arbit;

    localparam int MAX_CYC = 16;
    localparam int S_IDLE = 0, S_ARB = 1, S_AREF = 2, S_WR = 3, S_RD = 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic        initEnd;
    logic [3:0]  initCmd, arefCmd, wrCmd, rdCmd;
    logic [11:0] initAddr, arefAddr, wrAddr, rdAddr;
    logic [1:0]  wrBank, rdBank;
    logic        refReq, wrReq, rdReq;
    logic        flagRefEnd, flagWrEnd, flagRdEnd;
    logic        refEn, wrEn, rdEn, refBreak, timeoutErr;
    logic [3:0]  sdramCmd;
    logic [11:0] sdramAddr;
    logic [1:0]  sdramBank;
    logic [4:0]  arbState;

    int checks = 0;
    int errors = 0;

    int   mState, mSvc;
    logic mRefEn, mWrEn, mRdEn, mBreak, mErr, mLastWr;

    sdram_arbit #(.MAX_CYC(MAX_CYC), .CNT_W(4)) dut (
        .i_clk           (clk),
        .i_rst_n         (rstN),
        .i_flag_init_end (initEnd),
        .i_init_cmd      (initCmd),
        .i_init_addr     (initAddr),
        .i_ref_req       (refReq),
        .i_flag_ref_end  (flagRefEnd),
        .i_aref_cmd      (arefCmd),
        .i_aref_addr     (arefAddr),
        .i_wr_req        (wrReq),
        .i_flag_wr_end   (flagWrEnd),
        .i_wr_cmd        (wrCmd),
        .i_wr_addr       (wrAddr),
        .i_wr_bank       (wrBank),
        .i_rd_req        (rdReq),
        .i_flag_rd_end   (flagRdEnd),
        .i_rd_cmd        (rdCmd),
        .i_rd_addr       (rdAddr),
        .i_rd_bank       (rdBank),
        .o_ref_en        (refEn),
        .o_wr_en         (wrEn),
        .o_rd_en         (rdEn),
        .o_ref_break     (refBreak),
        .o_sdram_cmd     (sdramCmd),
        .o_sdram_addr    (sdramAddr),
        .o_sdram_bank    (sdramBank),
        .o_arb_state     (arbState),
        .o_timeout_err   (timeoutErr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed still running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] expectedPins();
        case (mState)
            S_IDLE:  return {initCmd, initAddr, 2'b00};
            S_AREF:  return {arefCmd, arefAddr, 2'b00};
            S_WR:    return {wrCmd, wrAddr, wrBank};
            S_RD:    return {rdCmd, rdAddr, rdBank};
            default: return {4'b0111, 12'd0, 2'b00};
        endcase
    endfunction

    task automatic checkAll();
        checkOutput("arbState", 32'(arbState), 32'(1 << mState));
        checkOutput("refEn", 32'(refEn), 32'(mRefEn));
        checkOutput("wrEn", 32'(wrEn), 32'(mWrEn));
        checkOutput("rdEn", 32'(rdEn), 32'(mRdEn));
        checkOutput("refBreak", 32'(refBreak), 32'(mBreak));
        checkOutput("timeoutErr", 32'(timeoutErr), 32'(mErr));
        checkOutput("pins", 32'({sdramCmd, sdramAddr, sdramBank}), 32'(expectedPins()));
    endtask

    task automatic modelReset();
        mState = S_IDLE; mSvc = 0;
        mRefEn = 0; mWrEn = 0; mRdEn = 0; mBreak = 0; mErr = 0; mLastWr = 0;
    endtask

    // One clock: fresh bus data, predict from current inputs, advance, compare.
    task automatic applyStimulus();
        int nState, nSvc;
        logic nRef, nWr, nRd, nBreak, nErr, nLast, endFlag;
        initCmd = 4'($urandom);  initAddr = 12'($urandom);
        arefCmd = 4'($urandom);  arefAddr = 12'($urandom);
        wrCmd = 4'($urandom);    wrAddr = 12'($urandom);  wrBank = 2'($urandom);
        rdCmd = 4'($urandom);    rdAddr = 12'($urandom);  rdBank = 2'($urandom);
        nState = mState; nSvc = mSvc + 1;
        nRef = 0; nWr = 0; nRd = 0; nErr = mErr; nLast = mLastWr; endFlag = 0;
        nBreak = ((mState == S_WR) || (mState == S_RD)) && refReq;
        case (mState)
            S_IDLE: if (initEnd) nState = S_ARB;
            S_ARB: begin
                if (refReq) begin
                    nState = S_AREF; nRef = 1; nSvc = 1;
                end else if (wrReq && !(rdReq && mLastWr)) begin
                    nState = S_WR; nWr = 1; nLast = 1; nSvc = 1;
                end else if (rdReq) begin
                    nState = S_RD; nRd = 1; nLast = 0; nSvc = 1;
                end
            end
            default: begin
                endFlag = (mState == S_AREF) ? flagRefEnd :
                          (mState == S_WR)   ? flagWrEnd  : flagRdEnd;
                if (endFlag) begin
                    nState = S_ARB;
                end else if (mSvc == MAX_CYC) begin
                    nState = S_ARB; nErr = 1;
                end
            end
        endcase
        @(posedge clk);
        mState = nState; mSvc = nSvc; mRefEn = nRef; mWrEn = nWr; mRdEn = nRd;
        mBreak = nBreak; mErr = nErr; mLastWr = nLast;
        #1;
        checkAll();
    endtask

    initial begin
        int inRead, waited;
        logic wasWrite;
        rstN = 0; initEnd = 0;
        refReq = 0; wrReq = 0; rdReq = 0;
        flagRefEnd = 0; flagWrEnd = 0; flagRdEnd = 0;
        initCmd = 0; initAddr = 0; arefCmd = 0; arefAddr = 0;
        wrCmd = 0; wrAddr = 0; wrBank = 0; rdCmd = 0; rdAddr = 0; rdBank = 0;
        modelReset();
        #12;
        checkAll();
        rstN = 1;

        $display("[TB] init handoff");
        repeat (200) applyStimulus();
        initEnd = 1;
        applyStimulus();
        checkOutput("initToArbit", 32'(arbState), 32'h02);
        checkOutput("arbitNop", 32'(sdramCmd), 32'h7);

        $display("[TB] refresh priority");
        refReq = 1; wrReq = 1; rdReq = 1;
        applyStimulus();
        checkOutput("refGrant", 32'({refEn, wrEn, rdEn}), 32'b100);
        refReq = 0;
        repeat (3) applyStimulus();
        flagRefEnd = 1;
        applyStimulus();
        flagRefEnd = 0;
        checkOutput("refToArbit", 32'(arbState), 32'h02);
        applyStimulus();
        checkOutput("wrAfterRef", 32'({arbState, wrEn}), 32'({5'b01000, 1'b1}));

        $display("[TB] fairness");
        for (int g = 0; g < 4; g++) begin
            if (g > 0) begin
                waited = 0;
                while (!(wrEn || rdEn) && waited < 10) begin
                    applyStimulus();
                    waited++;
                end
                checkOutput("grantSeen", 32'(wrEn | rdEn), 32'd1);
            end
            checkOutput("grantOrder", 32'(wrEn), 32'(g % 2 == 0));
            wasWrite = wrEn;
            repeat (7) applyStimulus();
            if (wasWrite) flagWrEnd = 1; else flagRdEnd = 1;
            applyStimulus();
            flagWrEnd = 0; flagRdEnd = 0;
        end
        wrReq = 0; rdReq = 0;
        applyStimulus();

        $display("[TB] refresh during write");
        wrReq = 1;
        applyStimulus();
        wrReq = 0;
        repeat (2) applyStimulus();
        refReq = 1;
        applyStimulus();
        checkOutput("refBreakSet", 32'(refBreak), 32'd1);
        applyStimulus();
        flagWrEnd = 1;
        applyStimulus();
        flagWrEnd = 0;
        applyStimulus();
        checkOutput("arefAfterBreak", 32'(arbState), 32'h04);
        refReq = 0;
        flagRefEnd = 1;
        applyStimulus();
        flagRefEnd = 0;

        $display("[TB] end flag at the cycle limit");
        wrReq = 1;
        applyStimulus();
        wrReq = 0;
        repeat (MAX_CYC - 1) applyStimulus();
        flagWrEnd = 1;
        applyStimulus();
        flagWrEnd = 0;
        checkOutput("endAtLimitState", 32'(arbState), 32'h02);
        checkOutput("endAtLimitErr", 32'(timeoutErr), 32'd0);

        $display("[TB] read timeout");
        rdReq = 1;
        applyStimulus();
        rdReq = 0;
        inRead = 1;
        while (arbState == 5'b10000 && inRead < 40) begin
            applyStimulus();
            if (arbState == 5'b10000) inRead++;
        end
        checkOutput("timeoutLen", 32'(inRead), 32'(MAX_CYC));
        checkOutput("timeoutErrSet", 32'(timeoutErr), 32'd1);
        repeat (5) applyStimulus();
        checkOutput("timeoutErrSticky", 32'(timeoutErr), 32'd1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            refReq = ($urandom_range(0, 9) == 0);
            wrReq = 1'($urandom);
            rdReq = 1'($urandom);
            flagRefEnd = ($urandom_range(0, 5) == 0);
            flagWrEnd = ($urandom_range(0, 5) == 0);
            flagRdEnd = ($urandom_range(0, 5) == 0);
            applyStimulus();
        end
        refReq = 0; wrReq = 0; rdReq = 0;
        flagRefEnd = 0; flagWrEnd = 0; flagRdEnd = 0;
        waited = 0;
        while (arbState !== 5'b00010 && waited < 40) begin
            applyStimulus();
            waited++;
        end
        checkOutput("reachArbit", 32'(arbState), 32'h02);

        $display("[TB] async reset during read");
        rdReq = 1;
        applyStimulus();
        rdReq = 0;
        repeat (2) applyStimulus();
        #3;
        rstN = 0;
        modelReset();
        #1;
        checkAll();
        checkOutput("rstState", 32'(arbState), 32'h01);
        checkOutput("rstFlags", 32'({refEn, wrEn, rdEn, refBreak, timeoutErr}), 32'd0);
        @(negedge clk);
        rstN = 1;
        applyStimulus();
        checkOutput("rearbitAfterRst", 32'(arbState), 32'h02);
        applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
